// File: rtl/reg_file_mp_pkg.sv
// Shared datapath constants and helpers for the multi-port register file.
package reg_file_mp_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_ZERO   = 0;

    typedef enum logic {
        RD_COMB = 1'b0,
        RD_REG  = 1'b1
    } rd_mode_e;

    // An address is usable when it is inside the array and is not the hardwired-zero register.
    function automatic logic addr_legal(input int unsigned addr, input int unsigned depth,
                                        input logic zero_reg);
        return (addr < depth) && !(zero_reg && (addr == REG_ZERO));
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port: write bypass priority mux, zero/range masking, optional output register.
module reg_file_rd_port
    import reg_file_mp_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEF,
    parameter int unsigned ADDR_W       = REG_ADDR_W,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned BYPASS       = 1,
    parameter int unsigned ZERO_REG     = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   stored_i,
    input  logic              wr0_ok_i,
    input  logic [ADDR_W-1:0] wr0_addr_i,
    input  logic [XLEN-1:0]   wr0_data_i,
    input  logic              wr1_ok_i,
    input  logic [ADDR_W-1:0] wr1_addr_i,
    input  logic [XLEN-1:0]   wr1_data_i,
    output logic [XLEN-1:0]   data_o
);

    localparam rd_mode_e MODE = (READ_LATENCY != 0) ? RD_REG : RD_COMB;

    logic [XLEN-1:0] rd_data_d;
    logic            unused_ok;

    assign unused_ok = ^{clk_i, rst_i, wr0_ok_i, wr0_addr_i, wr0_data_i,
                         wr1_ok_i, wr1_addr_i, wr1_data_i};

    always_comb begin
        rd_data_d = stored_i;
        if (BYPASS != 0) begin
            if (wr1_ok_i && (wr1_addr_i == addr_i)) begin
                rd_data_d = wr1_data_i;
            end else if (wr0_ok_i && (wr0_addr_i == addr_i)) begin
                rd_data_d = wr0_data_i;
            end
        end
        if (!addr_legal(32'(addr_i), DEPTH, ZERO_REG != 0)) begin
            rd_data_d = '0;
        end
    end

    if (MODE == RD_REG) begin : g_reg
        logic [XLEN-1:0] rd_data_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rd_data_q <= '0;
            end else begin
                rd_data_q <= rd_data_d;
            end
        end

        assign data_o = rd_data_q;
    end else begin : g_comb
        assign data_o = rd_data_d;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: two write ports (port 1 wins), NUM_RD independent read ports.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEF,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned NUM_RD       = 2,
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned BYPASS       = 1,
    parameter int unsigned ZERO_REG     = 1,
    localparam int unsigned ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [XLEN-1:0]          wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [XLEN-1:0]          wr1_data
);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic            wr0_ok;
    logic            wr1_ok;

    // Gating with reset keeps a write suppressed by reset from being bypassed to readers.
    assign wr0_ok = wr0_en && !reset && addr_legal(32'(wr0_addr), DEPTH, ZERO_REG != 0);
    assign wr1_ok = wr1_en && !reset && addr_legal(32'(wr1_addr), DEPTH, ZERO_REG != 0);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            if (wr0_ok) begin
                mem_q[wr0_addr] <= wr0_data;
            end
            if (wr1_ok) begin
                mem_q[wr1_addr] <= wr1_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr_g;

        assign addr_g = rd_addr[g*ADDR_W +: ADDR_W];

        reg_file_rd_port #(
            .XLEN        (XLEN),
            .ADDR_W      (ADDR_W),
            .DEPTH       (DEPTH),
            .READ_LATENCY(READ_LATENCY),
            .BYPASS      (BYPASS),
            .ZERO_REG    (ZERO_REG)
        ) u_rd_port (
            .clk_i     (sysclk),
            .rst_i     (reset),
            .addr_i    (addr_g),
            .stored_i  (mem_q[addr_g]),
            .wr0_ok_i  (wr0_ok),
            .wr0_addr_i(wr0_addr),
            .wr0_data_i(wr0_data),
            .wr1_ok_i  (wr1_ok),
            .wr1_addr_i(wr1_addr),
            .wr1_data_i(wr1_data),
            .data_o    (rd_data[g*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three configurations driven in lockstep against an array-based model.
module tb_reg_file_mp;

    logic        sysclk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic        wr0_en;
    logic [4:0]  wr0_addr;
    logic [31:0] wr0_data;
    logic        wr1_en;
    logic [4:0]  wr1_addr;
    logic [31:0] wr1_data;
    logic [63:0] dA;
    logic [63:0] dB;
    logic [63:0] dC;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] mem [32];
    logic [31:0] prevB [2];
    bit          prev_valid = 1'b0;

    always #5 sysclk = ~sysclk;

    // A: combinational + bypass, B: registered + bypass, C: combinational, no bypass, 24 entries
    reg_file_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .READ_LATENCY(0), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .sysclk(sysclk), .reset(reset), .rd_addr(rd_addr), .rd_data(dA),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data));

    reg_file_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .READ_LATENCY(1), .BYPASS(1), .ZERO_REG(1)) dut_b (
        .sysclk(sysclk), .reset(reset), .rd_addr(rd_addr), .rd_data(dB),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data));

    reg_file_mp #(.XLEN(32), .DEPTH(24), .NUM_RD(2), .READ_LATENCY(0), .BYPASS(0), .ZERO_REG(1)) dut_c (
        .sysclk(sysclk), .reset(reset), .rd_addr(rd_addr), .rd_data(dC),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data));

    // Value the register will hold once the pending writes land (port 1 applied last).
    function automatic logic [31:0] post_val(input logic [4:0] a);
        logic [31:0] v;
        v = mem[a];
        if (wr0_en && wr0_addr == a) v = wr0_data;
        if (wr1_en && wr1_addr == a) v = wr1_data;
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit byp, input int unsigned depth);
        if (a == 5'd0 || 32'(a) >= depth) return 32'h0;
        return byp ? post_val(a) : mem[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst,
                        input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] r0, input logic [4:0] r1);
        logic [4:0]  ra [2];
        logic [31:0] nextB [2];
        ra[0] = r0;
        ra[1] = r1;
        reset    = rst;
        wr0_en   = e0;
        wr0_addr = a0;
        wr0_data = d0;
        wr1_en   = e1;
        wr1_addr = a1;
        wr1_data = d1;
        rd_addr  = {r1, r0};
        #2;
        for (int unsigned p = 0; p < 2; p++) begin
            if (prev_valid) chk($sformatf("B_hold%0d", p), dB[p*32 +: 32], prevB[p]);
            if (!rst) begin
                chk($sformatf("A_pre%0d", p), dA[p*32 +: 32], model_read(ra[p], 1'b1, 32));
                chk($sformatf("C_pre%0d", p), dC[p*32 +: 32], model_read(ra[p], 1'b0, 24));
            end
            nextB[p] = rst ? 32'h0 : model_read(ra[p], 1'b1, 32);
        end
        @(posedge sysclk);
        if (rst) begin
            for (int unsigned k = 0; k < 32; k++) mem[k] = 32'h0;
        end else begin
            if (e0 && a0 != 5'd0) mem[a0] = d0;
            if (e1 && a1 != 5'd0) mem[a1] = d1;
        end
        #1;
        for (int unsigned p = 0; p < 2; p++) begin
            chk($sformatf("B_reg%0d", p), dB[p*32 +: 32], nextB[p]);
            if (!rst) begin
                chk($sformatf("A_post%0d", p), dA[p*32 +: 32], model_read(ra[p], 1'b1, 32));
                chk($sformatf("C_post%0d", p), dC[p*32 +: 32], model_read(ra[p], 1'b0, 24));
            end
            prevB[p] = nextB[p];
        end
        prev_valid = 1'b1;
    endtask

    initial begin
        // reset, then read x1/x2
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        // sequential writes, then read x1 on port 0 and x3 on port 1
        step(1'b0, 1'b1, 5'd3, 32'h00000001, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        step(1'b0, 1'b1, 5'd1, 32'h01234567, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        step(1'b0, 1'b1, 5'd2, 32'hffffffff, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd3);
        // x0 ignores writes
        step(1'b0, 1'b1, 5'd0, 32'hdeadbeef, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hdeadbeef, 5'd0, 5'd0);
        // collision on x5: port 1 wins, visible same cycle through bypass
        step(1'b0, 1'b1, 5'd5, 32'haaaa0000, 1'b1, 5'd5, 32'h5555ffff, 5'd5, 5'd5);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd1);
        // registered read latency on x7
        step(1'b0, 1'b1, 5'd7, 32'h00000011, 1'b0, 5'd0, 32'h0, 5'd3, 5'd1);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd3);
        // out-of-range reads on the 24-entry instance
        step(1'b0, 1'b1, 5'd25, 32'h12345678, 1'b1, 5'd23, 32'h87654321, 5'd25, 5'd23);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd25, 5'd23);
        // reset overrides a same-cycle write
        step(1'b1, 1'b1, 5'd4, 32'h0000cafe, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd7);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd7);
        // random traffic concentrated on low registers to provoke collisions and bypass hits
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(31) == 0),
                 1'($urandom_range(1)), 5'($urandom_range(11)), $urandom,
                 1'($urandom_range(1)), 5'($urandom_range(11)), $urandom,
                 5'($urandom_range(11)), 5'($urandom_range(31)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
